// File: rtl/fpga_pkg.sv
// rtl/fpga_pkg.sv - board clock rates, blink defaults and divider sizing helper
package fpga_pkg;

  localparam int SYS_CLK_HZ       = 50_000_000;
  localparam int AUX_CLK_HZ       = 27_000_000;
  localparam int BLINK_HZ_DEFAULT = 1;

  // Width of a counter spanning 0..half-1; never below one bit so HALF=1 stays legal.
  function automatic int cnt_width(input int half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/fpga_blink_div.sv
// rtl/fpga_blink_div.sv - square-wave divider toggling blink every HALF_PERIOD clocks
module blink_div
  import fpga_pkg::*;
#(
  parameter int HALF_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic nrst,
  output logic blink
);

  localparam int CW = cnt_width(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 1) begin : g_bad_half
    $error("blink_div: HALF_PERIOD must be at least 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga.sv
// rtl/fpga.sv - board top: switch/reset mirrors to LEDs, two blink dividers, aux oscillator enable
module fpga
  import fpga_pkg::*;
#(
  parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int LED1_HZ     = BLINK_HZ_DEFAULT,
  parameter int LED2_HZ     = BLINK_HZ_DEFAULT
) (
  input  logic fpga_CLK,
  input  logic fpga_NRST,
  input  logic fpga_CLK_AUX,
  input  logic fpga_SW0,
  input  logic fpga_SW1,
  output logic fpga_LEDR0,
  output logic fpga_LEDR1,
  output logic fpga_LEDR2,
  output logic fpga_LEDR3,
  output logic fpga_SEL_CLK_AUX
);

  localparam int HALF1 = CLK_FREQ_HZ / (2 * LED1_HZ);
  localparam int HALF2 = CLK_FREQ_HZ / (2 * LED2_HZ);

  if (CLK_FREQ_HZ % (2 * LED1_HZ) != 0) begin : g_bad_ratio1
    $error("fpga: CLK_FREQ_HZ not an integer multiple of 2*LED1_HZ");
  end
  if (CLK_FREQ_HZ % (2 * LED2_HZ) != 0) begin : g_bad_ratio2
    $error("fpga: CLK_FREQ_HZ not an integer multiple of 2*LED2_HZ");
  end
  if (HALF1 < 1 || HALF2 < 1) begin : g_bad_half
    $error("fpga: blink half-periods must be at least one clock");
  end

  // The aux clock pin exists only for pinout compatibility.
  logic unused_clk_aux;
  assign unused_clk_aux = fpga_CLK_AUX;

  assign fpga_LEDR0       = fpga_SW0;
  assign fpga_SEL_CLK_AUX = fpga_SW1;
  assign fpga_LEDR3       = fpga_NRST;

  blink_div #(.HALF_PERIOD(HALF1)) u_blink1 (
    .clk   (fpga_CLK),
    .nrst  (fpga_NRST),
    .blink (fpga_LEDR1)
  );

  blink_div #(.HALF_PERIOD(HALF2)) u_blink2 (
    .clk   (fpga_CLK),
    .nrst  (fpga_NRST),
    .blink (fpga_LEDR2)
  );

endmodule

// File: tb/tb_fpga.sv
// tb/tb_fpga.sv - directed self-checking bench for fpga at a 1 kHz nominal clock
module tb_fpga;

  logic clk = 1'b0;
  logic nrst, clk_aux, sw0, sw1;
  logic ledr0, ledr1, ledr2, ledr3, sel_aux;
  int   errors = 0;
  int   checks = 0;
  int   n, total;

  localparam int HALF = 500;

  fpga #(.CLK_FREQ_HZ(1000), .LED1_HZ(1), .LED2_HZ(1)) dut (
    .fpga_CLK         (clk),
    .fpga_NRST        (nrst),
    .fpga_CLK_AUX     (clk_aux),
    .fpga_SW0         (sw0),
    .fpga_SW1         (sw1),
    .fpga_LEDR0       (ledr0),
    .fpga_LEDR1       (ledr1),
    .fpga_LEDR2       (ledr2),
    .fpga_LEDR3       (ledr3),
    .fpga_SEL_CLK_AUX (sel_aux)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count rising edges until LEDR1 reaches level, sampling 1 time unit after each edge.
  task automatic wait_ledr1(input logic level, output int cnt);
    cnt = 0;
    while (ledr1 !== level && cnt < 4 * HALF) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    nrst = 1'b0; clk_aux = 1'b0; sw0 = 1'b0; sw1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_ledr3", ledr3, 0);
    check("rst_ledr1", ledr1, 0);
    check("rst_ledr2", ledr2, 0);
    check("rst_ledr0", ledr0, 0);
    check("rst_sel",   sel_aux, 0);

    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("rel_ledr3_async", ledr3, 1);
    @(posedge clk);
    #1;
    check("rel_ledr3_edge", ledr3, 1);
    wait_ledr1(1'b1, n);
    check("first_rise_clocks", n + 1, HALF);
    check("first_rise_ledr2", ledr2, 1);

    wait_ledr1(1'b0, n);
    check("high_half_clocks", n, HALF);
    check("fall_ledr2", ledr2, 0);
    wait_ledr1(1'b1, total);
    total = total + n;
    check("rise_to_rise_clocks", total, 2 * HALF);
    check("rise_ledr2", ledr2, 1);

    @(negedge clk); sw0 = 1'b1;
    @(posedge clk); #1;
    check("sw0_rise", ledr0, 1);
    @(negedge clk); sw0 = 1'b0;
    @(posedge clk); #1;
    check("sw0_fall", ledr0, 0);
    @(negedge clk); sw1 = 1'b1;
    @(posedge clk); #1;
    check("sw1_rise", sel_aux, 1);
    for (int i = 0; i < 8; i++) begin
      #2 clk_aux = ~clk_aux;
    end
    check("aux_ledr0", ledr0, 0);
    check("aux_sel",   sel_aux, 1);
    check("aux_ledr3", ledr3, 1);
    check("aux_ledr1", ledr1, 1);

    // LEDR1 is high here, a few clocks into its high half.
    @(negedge clk);
    #5 nrst = 1'b0;
    #1;
    check("mid_rst_ledr1", ledr1, 0);
    check("mid_rst_ledr2", ledr2, 0);
    check("mid_rst_ledr3", ledr3, 0);
    sw0 = 1'b1;
    #1;
    check("mid_rst_ledr0_follows", ledr0, 1);
    check("mid_rst_sel_follows", sel_aux, 1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold_ledr1", ledr1, 0);
    @(negedge clk);
    nrst = 1'b1;
    wait_ledr1(1'b1, n);
    check("rerelease_rise_clocks", n, HALF);
    check("rerelease_ledr2", ledr2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
